// File: rtl/sphere_pair_fetcher.sv
// Sphere-pair fetcher: walks a sphere table in synchronous RAM, enumerates
// every unordered pair (i<j), loads the eight operands for each pair and
// holds them for the collider until it reports done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start after reset
// LOAD_I  | reading sphere i (slots 0..3) and sphere j (slots 4..7)
// LOAD_J  | reading only sphere j (slots 4..7); sphere i operands kept
// PRESENT | pair complete and stable, waiting for collide_done
// DONE    | every pair consumed; end_of_memory held until start or rst
module sphere_pair_fetcher #(
  parameter int IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_W-1:0]     num_spheres,
  output logic                 mem_rd,
  output logic [IDX_W+1:0]     mem_addr,
  input  logic [31:0]          mem_rdata,
  output logic [31:0]          x1,
  output logic [31:0]          y1,
  output logic [31:0]          z1,
  output logic [31:0]          r1,
  output logic [31:0]          x2,
  output logic [31:0]          y2,
  output logic [31:0]          z2,
  output logic [31:0]          r2,
  output logic [IDX_W-1:0]     idx1,
  output logic [IDX_W-1:0]     idx2,
  output logic                 pair_valid,
  input  logic                 collide_done,
  output logic                 busy,
  output logic                 end_of_memory,
  output logic [2*IDX_W-1:0]   pairs_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_I,
    ST_LOAD_J,
    ST_PRESENT,
    ST_DONE
  } state_t;

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO = IDX_W'(2);

  state_t           state;
  logic [IDX_W-1:0] n_lat;
  logic [IDX_W-1:0] i_idx;
  logic [IDX_W-1:0] j_idx;
  // operand slot of the read currently driven on mem_rd (0..3 -> i, 4..7 -> j)
  logic [2:0]       rd_slot;
  // read that the RAM is servicing this cycle; its data is captured next edge
  logic             cap_vld;
  logic [2:0]       cap_slot;

  logic [2:0]         nxt_slot;
  logic [IDX_W+1:0]   nxt_addr;

  // Address of the read that follows the one now on the bus.
  always_comb begin
    nxt_slot = rd_slot + 3'd1;
    nxt_addr = {(nxt_slot[2] ? j_idx : i_idx), nxt_slot[1:0]};
  end

  // Sequencer, read pipeline and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      n_lat         <= '0;
      i_idx         <= '0;
      j_idx         <= '0;
      rd_slot       <= '0;
      cap_vld       <= 1'b0;
      cap_slot      <= '0;
      mem_rd        <= 1'b0;
      mem_addr      <= '0;
      x1            <= '0;
      y1            <= '0;
      z1            <= '0;
      r1            <= '0;
      x2            <= '0;
      y2            <= '0;
      z2            <= '0;
      r2            <= '0;
      idx1          <= '0;
      idx2          <= '0;
      pair_valid    <= 1'b0;
      busy          <= 1'b0;
      end_of_memory <= 1'b0;
      pairs_done    <= '0;
    end else begin
      cap_vld  <= mem_rd;
      cap_slot <= rd_slot;

      if (cap_vld) begin
        case (cap_slot)
          3'd0:    x1 <= mem_rdata;
          3'd1:    y1 <= mem_rdata;
          3'd2:    z1 <= mem_rdata;
          3'd3:    r1 <= mem_rdata;
          3'd4:    x2 <= mem_rdata;
          3'd5:    y2 <= mem_rdata;
          3'd6:    z2 <= mem_rdata;
          default: r2 <= mem_rdata;
        endcase
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            n_lat         <= num_spheres;
            i_idx         <= '0;
            j_idx         <= ONE;
            pairs_done    <= '0;
            end_of_memory <= 1'b0;
            if (num_spheres < TWO) begin
              state         <= ST_DONE;
              end_of_memory <= 1'b1;
              busy          <= 1'b0;
            end else begin
              state    <= ST_LOAD_I;
              busy     <= 1'b1;
              mem_rd   <= 1'b1;
              mem_addr <= '0;
              rd_slot  <= 3'd0;
            end
          end
        end

        ST_LOAD_I, ST_LOAD_J: begin
          if (mem_rd) begin
            if (rd_slot == 3'd7) begin
              mem_rd <= 1'b0;
            end else begin
              rd_slot  <= nxt_slot;
              mem_addr <= nxt_addr;
            end
          end
          // slot 7 is always the final word of either load
          if (cap_vld && cap_slot == 3'd7) begin
            pair_valid <= 1'b1;
            idx1       <= i_idx;
            idx2       <= j_idx;
            state      <= ST_PRESENT;
          end
        end

        ST_PRESENT: begin
          if (collide_done) begin
            pair_valid <= 1'b0;
            pairs_done <= pairs_done + 1'b1;
            if (j_idx < n_lat - ONE) begin
              j_idx    <= j_idx + ONE;
              state    <= ST_LOAD_J;
              mem_rd   <= 1'b1;
              mem_addr <= {j_idx + ONE, 2'd0};
              rd_slot  <= 3'd4;
            end else if (i_idx < n_lat - TWO) begin
              i_idx    <= i_idx + ONE;
              j_idx    <= i_idx + TWO;
              state    <= ST_LOAD_I;
              mem_rd   <= 1'b1;
              mem_addr <= {i_idx + ONE, 2'd0};
              rd_slot  <= 3'd0;
            end else begin
              state         <= ST_DONE;
              end_of_memory <= 1'b1;
              busy          <= 1'b0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sphere_pair_fetcher.sv
// Self-checking bench for sphere_pair_fetcher: a RAM model, a pair-queue
// reference model and one stimulus/compare process driven cycle by cycle.
module tb_sphere_pair_fetcher;
  localparam int IDX_W = 8;
  localparam int MEM_WORDS = 1 << (IDX_W + 2);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [IDX_W-1:0]     num_spheres = '0;
  logic                 mem_rd;
  logic [IDX_W+1:0]     mem_addr;
  logic [31:0]          mem_rdata = '0;
  logic [31:0]          x1, y1, z1, r1, x2, y2, z2, r2;
  logic [IDX_W-1:0]     idx1, idx2;
  logic                 pair_valid;
  logic                 collide_done = 1'b0;
  logic                 busy;
  logic                 end_of_memory;
  logic [2*IDX_W-1:0]   pairs_done;

  logic [31:0] mem [0:MEM_WORDS-1];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int consumed = 0;
  bit model_on = 1'b0;
  int exp_i[$];
  int exp_j[$];

  sphere_pair_fetcher #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_spheres(num_spheres),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .x1(x1), .y1(y1), .z1(z1), .r1(r1),
    .x2(x2), .y2(y2), .z2(z2), .r2(r2),
    .idx1(idx1), .idx2(idx2), .pair_valid(pair_valid),
    .collide_done(collide_done), .busy(busy),
    .end_of_memory(end_of_memory), .pairs_done(pairs_done)
  );

  always #5 clk = ~clk;

  // synchronous RAM: one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: update the model at the edge, compare at the falling edge.
  task automatic tick();
    logic cons;
    logic rnow;
    int a1;
    int a2;
    cons = model_on && !rst && pair_valid && collide_done;
    rnow = rst;
    @(posedge clk);
    if (rnow) begin
      model_on = 1'b0;
      exp_i.delete();
      exp_j.delete();
      consumed = 0;
    end else if (cons) begin
      if (exp_i.size() == 0) check("extra_consume", 64'd1, 64'd0);
      else begin
        void'(exp_i.pop_front());
        void'(exp_j.pop_front());
        consumed++;
      end
    end
    @(negedge clk);
    if (mem_rd) begin
      rd_cnt++;
      check("busy_during_rd", 64'(busy), 64'd1);
    end
    if (model_on && pair_valid) begin
      if (exp_i.size() == 0) check("extra_pair", 64'd1, 64'd0);
      else begin
        a1 = exp_i[0] * 4;
        a2 = exp_j[0] * 4;
        check("idx1", 64'(idx1), 64'(exp_i[0]));
        check("idx2", 64'(idx2), 64'(exp_j[0]));
        check("x1", 64'(x1), 64'(mem[a1]));
        check("y1", 64'(y1), 64'(mem[a1+1]));
        check("z1", 64'(z1), 64'(mem[a1+2]));
        check("r1", 64'(r1), 64'(mem[a1+3]));
        check("x2", 64'(x2), 64'(mem[a2]));
        check("y2", 64'(y2), 64'(mem[a2+1]));
        check("z2", 64'(z2), 64'(mem[a2+2]));
        check("r2", 64'(r2), 64'(mem[a2+3]));
        check("pairs_done_pv", 64'(pairs_done), 64'(consumed));
        check("busy_pv", 64'(busy), 64'd1);
        check("eom_pv", 64'(end_of_memory), 64'd0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_scan(input int n);
    exp_i.delete();
    exp_j.delete();
    for (int a = 0; a < n - 1; a++)
      for (int b = a + 1; b < n; b++) begin
        exp_i.push_back(a);
        exp_j.push_back(b);
      end
    consumed = 0;
    model_on = 1'b1;
    num_spheres = IDX_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    collide_done = 1'b1;
    tick();
    collide_done = 1'b0;
  endtask

  task automatic wait_pv(output int edges);
    edges = 0;
    while (!pair_valid && edges < 40) begin
      tick();
      edges++;
    end
    if (edges >= 40) check("pv_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_rest(input int n);
    int e;
    while (exp_i.size() > 0) begin
      wait_pv(e);
      if (e >= 40) break;
      repeat ($urandom_range(0, 3)) tick();
      pulse_done();
      if (exp_i.size() > 0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 1)) tick();
        pulse_done();
      end
    end
    tick();
    check("end_pairs_done", 64'(pairs_done), 64'(n * (n - 1) / 2));
    check("end_eom", 64'(end_of_memory), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("end_pv", 64'(pair_valid), 64'd0);
  endtask

  task automatic fill_ident();
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = 32'(a);
  endtask

  task automatic fill_rand();
    for (int a = 0; a < MEM_WORDS; a++) mem[a] = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_x1"}, 64'(x1), 64'd0);
    check({tag, "_r2"}, 64'(r2), 64'd0);
    check({tag, "_idx1"}, 64'(idx1), 64'd0);
    check({tag, "_idx2"}, 64'(idx2), 64'd0);
    check({tag, "_pv"}, 64'(pair_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_eom"}, 64'(end_of_memory), 64'd0);
    check({tag, "_pairs_done"}, 64'(pairs_done), 64'd0);
  endtask

  initial begin
    int e;
    int n;
    fill_ident();
    do_reset();
    check_all_zero("reset");

    // N=3 directed scan, RAM word a holds a
    rd_cnt = 0;
    start_scan(3);
    wait_pv(e);
    check("lat_first", 64'(e), 64'd9);
    check("rd_first", 64'(rd_cnt), 64'd8);
    check("lit_idx01", 64'({idx1, idx2}), 64'({8'd0, 8'd1}));
    repeat (2) tick();
    rd_cnt = 0;
    pulse_done();
    wait_pv(e);
    check("lat_load_j", 64'(e), 64'd5);
    check("rd_load_j", 64'(rd_cnt), 64'd4);
    check("lit_02_x1", 64'(x1), 64'd0);
    check("lit_02_x2", 64'(x2), 64'd8);
    check("lit_02_r2", 64'(r2), 64'd11);
    check("lit_02_idx2", 64'(idx2), 64'd2);
    repeat (2) tick();
    rd_cnt = 0;
    pulse_done();
    wait_pv(e);
    check("lat_load_i", 64'(e), 64'd9);
    check("rd_load_i", 64'(rd_cnt), 64'd8);
    check("lit_12_idx1", 64'(idx1), 64'd1);
    check("lit_12_x1", 64'(x1), 64'd4);
    repeat (2) tick();
    pulse_done();
    check("n3_pairs_done", 64'(pairs_done), 64'd3);
    check("n3_eom", 64'(end_of_memory), 64'd1);
    check("n3_busy", 64'(busy), 64'd0);

    // N=0 and N=1 finish at once without reads
    for (int k = 0; k < 2; k++) begin
      do_reset();
      rd_cnt = 0;
      start_scan(k);
      check("small_eom", 64'(end_of_memory), 64'd1);
      check("small_pairs_done", 64'(pairs_done), 64'd0);
      check("small_busy", 64'(busy), 64'd0);
      repeat (3) tick();
      check("small_no_rd", 64'(rd_cnt), 64'd0);
    end

    // stall, held done, done during load
    fill_rand();
    start_scan(4);
    wait_pv(e);
    repeat (100) tick();
    check("stall_x1", 64'(x1), 64'(mem[0]));
    check("stall_r2", 64'(r2), 64'(mem[7]));
    check("stall_idx2", 64'(idx2), 64'd1);
    check("stall_pairs_done", 64'(pairs_done), 64'd0);
    collide_done = 1'b1;
    repeat (3) tick();
    collide_done = 1'b0;
    check("held_done_once", 64'(pairs_done), 64'd1);
    wait_pv(e);
    pulse_done();
    wait_pv(e);
    pulse_done();
    tick();
    tick();
    pulse_done();
    check("done_in_load_i", 64'(pairs_done), 64'd3);
    run_rest(4);

    // reset in the middle of the first load
    fill_ident();
    start_scan(3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    rd_cnt = 0;
    repeat (3) tick();
    check("midrst_no_rd", 64'(rd_cnt), 64'd0);
    start_scan(3);
    wait_pv(e);
    check("midrst_lat", 64'(e), 64'd9);
    run_rest(3);

    // start ignored while presenting, honoured in DONE
    fill_rand();
    start_scan(3);
    wait_pv(e);
    num_spheres = IDX_W'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_start_pv", 64'(pair_valid), 64'd1);
    check("ign_start_busy", 64'(busy), 64'd1);
    run_rest(3);
    start_scan(2);
    check("restart_eom_clr", 64'(end_of_memory), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    wait_pv(e);
    check("restart_lat", 64'(e), 64'd9);
    check("restart_idx", 64'({idx1, idx2}), 64'({8'd0, 8'd1}));
    run_rest(2);

    // randomized scans
    repeat (6) begin
      fill_rand();
      n = $urandom_range(2, 7);
      start_scan(n);
      run_rest(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
